// File: rtl/mem_bank_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_bank_rr_arbiter_if
// Bundle of the PE-side memory ports and the SRAM-bank-side ports of the
// PE-to-bank crossbar arbiter.
//   PE side   : rden, wren, wstrb, addr, wdata  (requests, held until gnt)
//               gnt, rvalid, rdata               (responses)
//   Bank side : bank_en, bank_we, bank_addr, bank_wdata (strobes to SRAM)
//               bank_rdata                       (SRAM read data, 1-cycle latency)
// Modports:
//   slave  - the arbiter itself
//   master - the environment (PEs + SRAM banks)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface mem_bank_rr_arbiter_if #(
  parameter int NUM_PE   = 4,
  parameter int NUM_BANK = 4
);
  logic [NUM_PE-1:0]             rden;
  logic [NUM_PE-1:0]             wren;
  logic [NUM_PE-1:0][3:0]        wstrb;
  logic [NUM_PE-1:0][31:0]       addr;
  logic [NUM_PE-1:0][31:0]       wdata;
  logic [NUM_PE-1:0]             gnt;
  logic [NUM_PE-1:0]             rvalid;
  logic [NUM_PE-1:0][31:0]       rdata;
  logic [NUM_BANK-1:0]           bank_en;
  logic [NUM_BANK-1:0][3:0]      bank_we;
  logic [NUM_BANK-1:0][31:0]     bank_addr;
  logic [NUM_BANK-1:0][31:0]     bank_wdata;
  logic [NUM_BANK-1:0][31:0]     bank_rdata;

  modport slave (
    input  rden, wren, wstrb, addr, wdata, bank_rdata,
    output gnt, rvalid, rdata, bank_en, bank_we, bank_addr, bank_wdata
  );

  modport master (
    output rden, wren, wstrb, addr, wdata, bank_rdata,
    input  gnt, rvalid, rdata, bank_en, bank_we, bank_addr, bank_wdata
  );
endinterface

// File: rtl/mem_bank_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bank_rr_arbiter
// Round-robin arbiter and sequencer between the PE memory ports and the four
// SRAM banks. Each bank grants one requesting PE per cycle (combinational
// gnt), rotating its priority pointer past the winner. Read grants register
// the bank owner so the 1-cycle-latency SRAM data is routed back with rvalid.
//
// Ports:
//   clk_i   - core clock
//   rst_i   - asynchronous, active-high reset
//   bus     - mem_bank_rr_arbiter_if.slave (PE requests/responses, bank side)
//   conflict_cnt_o[NUM_BANK] - cycles with >=2 requesters per bank  (perf build)
//   stall_cnt_o[NUM_PE]      - cycles requesting without grant per PE (perf build)
//
// Build option: define MEM_ARB_PERF_EN to add the saturating 32-bit
// performance counters and their ports. Arbitration is identical either way.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module mem_bank_rr_arbiter #(
  parameter int NUM_PE   = 4,
  parameter int NUM_BANK = 4,   // 2-bit bank select: must be 4
  parameter int BANK_MSB = 15
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  mem_bank_rr_arbiter_if.slave       bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [NUM_BANK-1:0][31:0]  conflict_cnt_o,
  output logic [NUM_PE-1:0][31:0]    stall_cnt_o
`endif
);

  localparam int PTR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  logic [NUM_PE-1:0]               req;
  logic [NUM_PE-1:0][1:0]          bank_sel;
  logic [NUM_BANK-1:0][PTR_W-1:0]  ptr_q;
  logic [NUM_BANK-1:0]             win_vld;
  logic [NUM_BANK-1:0][PTR_W-1:0]  win_id;
  logic [NUM_BANK-1:0]             rd_pend_q;
  logic [NUM_BANK-1:0][PTR_W-1:0]  rd_owner_q;
  logic [NUM_PE-1:0]               gnt;
  logic [NUM_PE-1:0]               rvalid;
  logic [NUM_PE-1:0][31:0]         rdata_mux;
  logic [NUM_PE-1:0][31:0]         rdata_q;

  // NOTE: combinational processes assign every output a default first and use
  // blocking '='; this keeps them latch-free. Clocked processes use '<=' only.
  always_comb begin
    req      = '0;
    bank_sel = '0;
    for (int p = 0; p < NUM_PE; p++) begin
      req[p]      = bus.rden[p] | bus.wren[p];
      bank_sel[p] = bus.addr[p][BANK_MSB -: 2];
    end
  end

  // Winner per bank: first requester found scanning from the bank pointer.
  always_comb begin
    int idx;
    idx     = 0;
    win_vld = '0;
    win_id  = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      for (int k = 0; k < NUM_PE; k++) begin
        idx = int'(ptr_q[b]) + k;
        if (idx >= NUM_PE) idx = idx - NUM_PE;
        if (!win_vld[b] && req[idx] && (bank_sel[idx] == 2'(b))) begin
          win_vld[b] = 1'b1;
          win_id[b]  = PTR_W'(idx);
        end
      end
    end
  end

  // Grant and bank-side drive. A PE addresses one bank, so at most one bank
  // can set a given gnt bit. Everything is suppressed while reset is high.
  always_comb begin
    gnt            = '0;
    bus.bank_en    = '0;
    bus.bank_we    = '0;
    bus.bank_addr  = '0;
    bus.bank_wdata = '0;
    if (!rst_i) begin
      for (int b = 0; b < NUM_BANK; b++) begin
        if (win_vld[b]) begin
          gnt[win_id[b]]    = 1'b1;
          bus.bank_en[b]    = 1'b1;
          bus.bank_we[b]    = bus.wstrb[win_id[b]] & {4{bus.wren[win_id[b]]}};
          bus.bank_addr[b]  = bus.addr[win_id[b]];
          bus.bank_wdata[b] = bus.wdata[win_id[b]];
        end
      end
    end
  end

  assign bus.gnt = gnt;

  // Pointer rotation and read-owner bookkeeping. rden+wren together counts
  // as a write, so only pure reads leave a pending return.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      rd_pend_q  <= '0;
      rd_owner_q <= '0;
    end else begin
      for (int b = 0; b < NUM_BANK; b++) begin
        if (win_vld[b]) begin
          ptr_q[b] <= (int'(win_id[b]) == NUM_PE - 1) ? '0 : win_id[b] + 1'b1;
        end
        rd_pend_q[b]  <= win_vld[b] & ~bus.wren[win_id[b]];
        rd_owner_q[b] <= win_id[b];
      end
    end
  end

  // Read return: SRAM data of the owning bank is forwarded in the cycle it
  // arrives; otherwise each PE sees the last value it was given.
  always_comb begin
    rvalid    = '0;
    rdata_mux = rdata_q;
    for (int b = 0; b < NUM_BANK; b++) begin
      if (rd_pend_q[b]) begin
        rvalid[rd_owner_q[b]]    = 1'b1;
        rdata_mux[rd_owner_q[b]] = bus.bank_rdata[b];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rdata_q <= '0;
    else       rdata_q <= rdata_mux;
  end

  assign bus.rvalid = rvalid;
  assign bus.rdata  = rdata_mux;

`ifdef MEM_ARB_PERF_EN
  logic [NUM_BANK-1:0] conflict;

  always_comb begin
    int n_req;
    n_req    = 0;
    conflict = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      n_req = 0;
      for (int p = 0; p < NUM_PE; p++) begin
        if (req[p] && (bank_sel[p] == 2'(b))) n_req = n_req + 1;
      end
      conflict[b] = (n_req >= 2);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      conflict_cnt_o <= '0;
      stall_cnt_o    <= '0;
    end else begin
      for (int b = 0; b < NUM_BANK; b++) begin
        if (conflict[b] && (conflict_cnt_o[b] != '1))
          conflict_cnt_o[b] <= conflict_cnt_o[b] + 32'd1;
      end
      for (int p = 0; p < NUM_PE; p++) begin
        if (req[p] && !gnt[p] && (stall_cnt_o[p] != '1))
          stall_cnt_o[p] <= stall_cnt_o[p] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_bank_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bank_rr_arbiter
// Directed bench for mem_bank_rr_arbiter. A behavioural model picks each
// bank's winner as the requester with the smallest rotational distance from
// that bank's pointer; a compare process checks every output each cycle on
// the falling edge, and the directed sequences add literal expectations.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mem_bank_rr_arbiter;
  localparam int NP = 4;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_bank_rr_arbiter_if #(.NUM_PE(NP), .NUM_BANK(NB)) bus ();

`ifdef MEM_ARB_PERF_EN
  logic [NB-1:0][31:0] conflict_cnt;
  logic [NP-1:0][31:0] stall_cnt;
`endif

  mem_bank_rr_arbiter #(.NUM_PE(NP), .NUM_BANK(NB), .BANK_MSB(15)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef MEM_ARB_PERF_EN
    ,
    .conflict_cnt_o (conflict_cnt),
    .stall_cnt_o    (stall_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // SRAM content seen by reads: fixed pattern, with one pinned word.
  function automatic logic [31:0] sram_fn(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEAD_BEEF : {a[15:0], ~a[15:0]};
  endfunction

  // SRAM environment: latch the read strobe mid-cycle, return data at the edge.
  logic [NB-1:0]       sram_rd = '0;
  logic [NB-1:0][31:0] sram_a  = '0;
  always @(negedge clk) begin
    for (int b = 0; b < NB; b++) begin
      sram_rd[b] <= bus.bank_en[b] && (bus.bank_we[b] == 4'h0);
      sram_a[b]  <= bus.bank_addr[b];
    end
  end
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++)
      if (sram_rd[b]) bus.bank_rdata[b] <= sram_fn(sram_a[b]);
  end

  // ---------------- behavioural model ----------------
  int                  m_ptr [NB];
  logic [NP-1:0]       m_rv;
  logic [NP-1:0][31:0] m_rd;

  function automatic void model_win(output int win [NB]);
    int best;
    int d;
    for (int b = 0; b < NB; b++) begin
      win[b] = -1;
      best   = NP;
      for (int p = 0; p < NP; p++) begin
        if ((bus.rden[p] || bus.wren[p]) && (int'(bus.addr[p][15:14]) == b)) begin
          d = (p - m_ptr[b] + NP) % NP;
          if (d < best) begin
            best   = d;
            win[b] = p;
          end
        end
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin : model_update
    int win [NB];
    if (rst) begin
      for (int b = 0; b < NB; b++) m_ptr[b] <= 0;
      m_rv <= '0;
      m_rd <= '0;
    end else begin
      model_win(win);
      m_rv <= '0;
      for (int b = 0; b < NB; b++) begin
        if (win[b] >= 0) begin
          m_ptr[b] <= (win[b] + 1) % NP;
          if (!bus.wren[win[b]]) begin
            m_rv[win[b]] <= 1'b1;
            m_rd[win[b]] <= sram_fn(bus.addr[win[b]]);
          end
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    int            win [NB];
    logic [NP-1:0] e_gnt;
    logic [NB-1:0] e_en;
    if (!rst) begin
      model_win(win);
      e_gnt = '0;
      e_en  = '0;
      for (int b = 0; b < NB; b++) begin
        if (win[b] >= 0) begin
          e_gnt[win[b]] = 1'b1;
          e_en[b]       = 1'b1;
          check("bank_we",    32'(bus.bank_we[b]), 32'(bus.wstrb[win[b]] & {4{bus.wren[win[b]]}}));
          check("bank_addr",  bus.bank_addr[b],  bus.addr[win[b]]);
          check("bank_wdata", bus.bank_wdata[b], bus.wdata[win[b]]);
        end else begin
          check("idle_we",    32'(bus.bank_we[b]), 32'h0);
          check("idle_addr",  bus.bank_addr[b],  32'h0);
        end
      end
      check("gnt",     32'(bus.gnt),     32'(e_gnt));
      check("bank_en", 32'(bus.bank_en), 32'(e_en));
      check("rvalid",  32'(bus.rvalid),  32'(m_rv));
      for (int p = 0; p < NP; p++) check("rdata", bus.rdata[p], m_rd[p]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    bus.rden  = '0;
    bus.wren  = '0;
    bus.wstrb = '0;
    bus.addr  = '0;
    bus.wdata = '0;
  endtask

  task automatic pe_req(input int p, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    bus.rden[p]  = rd;
    bus.wren[p]  = wr;
    bus.addr[p]  = a;
    bus.wstrb[p] = s;
    bus.wdata[p] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    mid();
    check("rst_rvalid", 32'(bus.rvalid), 32'h0);
    check("rst_rdata0", bus.rdata[0], 32'h0);
    check("rst_gnt",    32'(bus.gnt), 32'h0);

    // Single read: PE0 -> bank0
    tick();
    pe_req(0, 1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0);
    mid();
    check("rd_gnt",     32'(bus.gnt),     32'h1);
    check("rd_bank_en", 32'(bus.bank_en), 32'h1);
    tick();
    idle();
    mid();
    check("rd_rvalid", 32'(bus.rvalid), 32'h1);
    check("rd_rdata",  bus.rdata[0],    32'hDEAD_BEEF);

    // All PEs read bank1 continuously: rotation PE0..PE3, PE0
    tick();
    for (int p = 0; p < NP; p++) pe_req(p, 1'b1, 1'b0, 32'h4000 + 32'(p * 4), 4'h0, 32'h0);
    for (int c = 0; c < 5; c++) begin
      mid();
      check("rr_order", 32'(bus.gnt), 32'(rr_exp[c]));
      tick();
    end
    idle();

    // PE1 writes bank2 while PE2 reads bank3
    tick();
    pe_req(1, 1'b0, 1'b1, 32'h8000, 4'b0011, 32'h1234_5678);
    pe_req(2, 1'b1, 1'b0, 32'hC000, 4'h0,    32'h0);
    mid();
    check("par_gnt",     32'(bus.gnt),        32'b0110);
    check("par_bank_en", 32'(bus.bank_en),    32'b1100);
    check("par_we2",     32'(bus.bank_we[2]), 32'b0011);
    check("par_wdata2",  bus.bank_wdata[2],   32'h1234_5678);
    tick();
    idle();
    mid();
    check("par_rvalid", 32'(bus.rvalid), 32'b0100);

    // PE3 rden+wren together is a write
    tick();
    pe_req(3, 1'b1, 1'b1, 32'h20, 4'b1111, 32'hCAFE_F00D);
    mid();
    check("rw_gnt", 32'(bus.gnt),        32'b1000);
    check("rw_we0", 32'(bus.bank_we[0]), 32'hF);
    tick();
    idle();
    mid();
    check("rw_no_rvalid", 32'(bus.rvalid), 32'h0);

    // Read granted, reset pulsed before the next edge
    tick();
    pe_req(1, 1'b1, 1'b0, 32'h8004, 4'h0, 32'h0);
    mid();
    check("rr_pre_rst_gnt", 32'(bus.gnt), 32'b0010);
    #2 rst = 1'b1;
    #1;
    check("in_rst_gnt",     32'(bus.gnt),     32'h0);
    check("in_rst_bank_en", 32'(bus.bank_en), 32'h0);
    check("in_rst_bank_we", 32'(bus.bank_we[2]), 32'h0);
    #1 rst = 1'b0;
    idle();
    tick();
    mid();
    check("post_rst_rvalid", 32'(bus.rvalid), 32'h0);
    check("post_rst_rdata2", bus.rdata[2],    32'h0);
    tick();
    for (int p = 0; p < NP; p++) pe_req(p, 1'b1, 1'b0, 32'h8000 + 32'(p * 4), 4'h0, 32'h0);
    mid();
    check("post_rst_ptr_gnt", 32'(bus.gnt), 32'b0001);
    tick();
    idle();

`ifdef MEM_ARB_PERF_EN
    mid();
    rst = 1'b1;
    #1 rst = 1'b0;
    tick();
    pe_req(0, 1'b1, 1'b0, 32'h0100, 4'h0, 32'h0);
    pe_req(1, 1'b1, 1'b0, 32'h0104, 4'h0, 32'h0);
    repeat (4) tick();
    idle();
    mid();
    check("conflict_cnt0", conflict_cnt[0], 32'd4);
    check("stall_cnt0",    stall_cnt[0],    32'd2);
    check("stall_cnt1",    stall_cnt[1],    32'd2);
`endif

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, limit 20000ns");
    $fatal(1, "timeout");
  end

endmodule
